// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L2 port arbiter and its picker.
package l2_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: bit 0 is the I-side, bit 1 the D-side.
// On contention, prio forces bit 1; otherwise the side that was not last served wins.
module rr_pick2
    import l2_arb_pkg::*;
(
    input  logic [1:0]  req,
    input  requester_t  last,
    input  logic        prio,
    output logic [1:0]  grant,
    output logic        valid
);

    always_comb begin
        grant = req;
        valid = |req;
        if (req == 2'b11) begin
            if (prio || (last == REQ_I)) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares one L2 port between the L1 I-cache and D-cache, holding each grant
// from request until mem_resp and steering the response only to the owner.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter bit DPRIO  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t state_q, state_d;
    requester_t last_q, last_d;
    logic [1:0] req;
    logic [1:0] grant;
    logic       pick_valid;

    assign req = {d_read | d_write, i_read};

    rr_pick2 u_pick (
        .req   (req),
        .last  (last_q),
        .prio  (DPRIO),
        .grant (grant),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= REQ_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Outputs depend only on the held grant, so IDLE (and reset) present an all-zero port.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_resp    = 1'b0;
        i_rdata   = '0;
        d_resp    = 1'b0;
        d_rdata   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid && grant[1]) begin
                    state_d = GRANT_D;
                    last_d  = REQ_D;
                end else if (pick_valid && grant[0]) begin
                    state_d = GRANT_I;
                    last_d  = REQ_I;
                end
            end
            GRANT_I: begin
                mem_read = i_read;
                mem_addr = i_addr;
                i_resp   = mem_resp;
                i_rdata  = mem_rdata;
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            GRANT_D: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_resp    = mem_resp;
                d_rdata   = mem_rdata;
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A simultaneous read and write from the D-cache is forwarded as-is but flagged.
    d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_l2_arbiter.sv
// Table-driven bench for l2_arbiter: one round-robin instance and one D-priority instance.
module tb_l2_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam logic [LW-1:0] A = {32{8'hA5}};
    localparam logic [LW-1:0] B = {32{8'h5A}};
    localparam logic [LW-1:0] C = {32{8'h3C}};
    localparam logic [LW-1:0] W = {8{32'h1234_5678}};
    localparam logic [LW-1:0] Z = '0;
    localparam logic [AW-1:0] I1 = 32'h0000_1000;
    localparam logic [AW-1:0] D1 = 32'h0000_2040;
    localparam logic [AW-1:0] D2 = 32'h0000_3000;
    localparam logic [AW-1:0] D3 = 32'h0000_3040;
    localparam logic [AW-1:0] D4 = 32'h0000_4000;
    localparam logic [AW-1:0] D5 = 32'h0000_5000;
    localparam logic [AW-1:0] D6 = 32'h0000_6000;
    localparam logic [AW-1:0] Z32 = '0;

    typedef struct {
        logic            rst_n;
        logic            i_read;
        logic [AW-1:0]   i_addr;
        logic            d_read;
        logic            d_write;
        logic [AW-1:0]   d_addr;
        logic [LW-1:0]   d_wdata;
        logic [LW-1:0]   mem_rdata;
        logic            mem_resp;
        logic            e_mem_read;
        logic            e_mem_write;
        logic [AW-1:0]   e_mem_addr;
        logic [LW-1:0]   e_mem_wdata;
        logic            e_i_resp;
        logic [LW-1:0]   e_i_rdata;
        logic            e_d_resp;
        logic [LW-1:0]   e_d_rdata;
    } vec_t;

    logic clk;
    int   checks;
    int   failures;

    logic rst_n0, i_read0, d_read0, d_write0, mem_resp0;
    logic [AW-1:0] i_addr0, d_addr0;
    logic [LW-1:0] d_wdata0, mem_rdata0;
    logic i_resp0, d_resp0, mem_read0, mem_write0;
    logic [AW-1:0] mem_addr0;
    logic [LW-1:0] i_rdata0, d_rdata0, mem_wdata0;

    logic rst_n1, i_read1, d_read1, d_write1, mem_resp1;
    logic [AW-1:0] i_addr1, d_addr1;
    logic [LW-1:0] d_wdata1, mem_rdata1;
    logic i_resp1, d_resp1, mem_read1, mem_write1;
    logic [AW-1:0] mem_addr1;
    logic [LW-1:0] i_rdata1, d_rdata1, mem_wdata1;

    l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .DPRIO(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n0),
        .i_read(i_read0), .i_addr(i_addr0), .i_rdata(i_rdata0), .i_resp(i_resp0),
        .d_read(d_read0), .d_write(d_write0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .d_rdata(d_rdata0), .d_resp(d_resp0),
        .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .mem_resp(mem_resp0)
    );

    l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .DPRIO(1'b1)) dut_dp (
        .clk(clk), .rst_n(rst_n1),
        .i_read(i_read1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_resp(i_resp1),
        .d_read(d_read1), .d_write(d_write1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_resp(d_resp1),
        .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .mem_resp(mem_resp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic ir, input logic [AW-1:0] ia,
        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [LW-1:0] dwd,
        input logic [LW-1:0] mrd, input logic mresp,
        input logic emr, input logic emw, input logic [AW-1:0] ema, input logic [LW-1:0] emwd,
        input logic eir, input logic [LW-1:0] eird, input logic edr, input logic [LW-1:0] edrd);
        vec_t v;
        v.rst_n = rst; v.i_read = ir; v.i_addr = ia;
        v.d_read = dr; v.d_write = dw; v.d_addr = da; v.d_wdata = dwd;
        v.mem_rdata = mrd; v.mem_resp = mresp;
        v.e_mem_read = emr; v.e_mem_write = emw; v.e_mem_addr = ema; v.e_mem_wdata = emwd;
        v.e_i_resp = eir; v.e_i_rdata = eird; v.e_d_resp = edr; v.e_d_rdata = edrd;
        return v;
    endfunction

    // Row whose required outputs are all zero (IDLE or reset).
    function automatic vec_t mkz(
        input logic rst, input logic ir, input logic [AW-1:0] ia,
        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [LW-1:0] dwd,
        input logic [LW-1:0] mrd, input logic mresp);
        return mk(rst, ir, ia, dr, dw, da, dwd, mrd, mresp, 1'b0, 1'b0, Z32, Z, 1'b0, Z, 1'b0, Z);
    endfunction

    task automatic chk(input string tag, input string name,
                       input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s %s: got %h required %h", tag, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int sel);
        if (sel == 0) begin
            rst_n0 = v.rst_n; i_read0 = v.i_read; i_addr0 = v.i_addr;
            d_read0 = v.d_read; d_write0 = v.d_write; d_addr0 = v.d_addr; d_wdata0 = v.d_wdata;
            mem_rdata0 = v.mem_rdata; mem_resp0 = v.mem_resp;
        end else begin
            rst_n1 = v.rst_n; i_read1 = v.i_read; i_addr1 = v.i_addr;
            d_read1 = v.d_read; d_write1 = v.d_write; d_addr1 = v.d_addr; d_wdata1 = v.d_wdata;
            mem_rdata1 = v.mem_rdata; mem_resp1 = v.mem_resp;
        end
    endtask

    task automatic checkOutput(input vec_t v, input int sel, input string tag);
        logic mr, mw, ir, dr;
        logic [AW-1:0] ma;
        logic [LW-1:0] mwd, ird, drd;
        if (sel == 0) begin
            mr = mem_read0; mw = mem_write0; ma = mem_addr0; mwd = mem_wdata0;
            ir = i_resp0; ird = i_rdata0; dr = d_resp0; drd = d_rdata0;
        end else begin
            mr = mem_read1; mw = mem_write1; ma = mem_addr1; mwd = mem_wdata1;
            ir = i_resp1; ird = i_rdata1; dr = d_resp1; drd = d_rdata1;
        end
        chk(tag, "mem_read", LW'(mr), LW'(v.e_mem_read));
        chk(tag, "mem_write", LW'(mw), LW'(v.e_mem_write));
        chk(tag, "mem_addr", LW'(ma), LW'(v.e_mem_addr));
        chk(tag, "mem_wdata", mwd, v.e_mem_wdata);
        chk(tag, "i_resp", LW'(ir), LW'(v.e_i_resp));
        chk(tag, "i_rdata", ird, v.e_i_rdata);
        chk(tag, "d_resp", LW'(dr), LW'(v.e_d_resp));
        chk(tag, "d_rdata", drd, v.e_d_rdata);
    endtask

    vec_t t_rr[$];
    vec_t t_dp[$];

    initial begin
        checks = 0;
        failures = 0;
        applyStimulus(mkz(1'b0, 0, Z32, 0, 0, Z32, Z, Z, 0), 0);
        applyStimulus(mkz(1'b0, 0, Z32, 0, 0, Z32, Z, Z, 0), 1);

        // Round-robin instance: lone I-read, D-write, IDLE resp, contention, back-to-back.
        t_rr.push_back(mkz(0, 0, Z32, 0, 1, D1, W, Z, 0));
        t_rr.push_back(mkz(1, 1, I1, 0, 0, Z32, Z, Z, 0));
        for (int k = 0; k < 4; k++)
            t_rr.push_back(mk(1, 1, I1, 0, 0, Z32, Z, Z, 0, 1, 0, I1, Z, 0, Z, 0, Z));
        t_rr.push_back(mk(1, 1, I1, 0, 0, Z32, Z, A, 1, 1, 0, I1, Z, 1, A, 0, Z));
        t_rr.push_back(mkz(1, 0, Z32, 0, 0, Z32, Z, A, 0));
        t_rr.push_back(mkz(1, 0, Z32, 0, 1, D1, W, Z, 0));
        t_rr.push_back(mk(1, 0, Z32, 0, 1, D1, W, A, 0, 0, 1, D1, W, 0, Z, 0, A));
        t_rr.push_back(mk(1, 0, Z32, 0, 1, D1, W, B, 1, 0, 1, D1, W, 0, Z, 1, B));
        t_rr.push_back(mkz(1, 0, Z32, 0, 0, Z32, Z, B, 0));
        t_rr.push_back(mkz(1, 0, Z32, 0, 0, Z32, Z, C, 1));
        t_rr.push_back(mkz(1, 1, I1, 0, 0, Z32, Z, Z, 0));
        t_rr.push_back(mkz(0, 1, I1, 0, 0, Z32, Z, Z, 0));
        t_rr.push_back(mkz(1, 1, I1, 1, 0, D2, W, Z, 0));
        t_rr.push_back(mk(1, 1, I1, 1, 0, D2, W, Z, 0, 1, 0, D2, W, 0, Z, 0, Z));
        t_rr.push_back(mk(1, 1, I1, 1, 0, D2, W, B, 1, 1, 0, D2, W, 0, Z, 1, B));
        t_rr.push_back(mkz(1, 1, I1, 1, 0, D3, W, Z, 0));
        t_rr.push_back(mk(1, 1, I1, 1, 0, D3, W, Z, 0, 1, 0, I1, Z, 0, Z, 0, Z));
        t_rr.push_back(mk(1, 1, I1, 1, 0, D3, W, C, 1, 1, 0, I1, Z, 1, C, 0, Z));
        t_rr.push_back(mkz(1, 1, I1, 1, 0, D3, W, Z, 0));
        t_rr.push_back(mk(1, 1, I1, 1, 0, D3, W, Z, 0, 1, 0, D3, W, 0, Z, 0, Z));
        t_rr.push_back(mk(1, 1, I1, 1, 0, D3, W, A, 1, 1, 0, D3, W, 0, Z, 1, A));
        t_rr.push_back(mkz(1, 0, Z32, 0, 0, Z32, Z, Z, 0));
        t_rr.push_back(mkz(1, 0, Z32, 1, 0, D4, Z, Z, 0));
        t_rr.push_back(mk(1, 0, Z32, 1, 0, D4, Z, A, 1, 1, 0, D4, Z, 0, Z, 1, A));
        t_rr.push_back(mkz(1, 0, Z32, 1, 0, D4, Z, Z, 0));
        t_rr.push_back(mk(1, 0, Z32, 1, 0, D4, Z, B, 1, 1, 0, D4, Z, 0, Z, 1, B));
        t_rr.push_back(mkz(1, 0, Z32, 0, 0, Z32, Z, Z, 0));

        // D-priority instance: D wins every contended round until it stops asking.
        t_dp.push_back(mkz(0, 1, I1, 1, 0, D5, W, Z, 0));
        t_dp.push_back(mkz(1, 1, I1, 1, 0, D5, W, Z, 0));
        t_dp.push_back(mk(1, 1, I1, 1, 0, D5, W, A, 1, 1, 0, D5, W, 0, Z, 1, A));
        t_dp.push_back(mkz(1, 1, I1, 1, 0, D5, W, Z, 0));
        t_dp.push_back(mk(1, 1, I1, 1, 0, D5, W, B, 1, 1, 0, D5, W, 0, Z, 1, B));
        t_dp.push_back(mkz(1, 1, I1, 1, 0, D5, W, Z, 0));
        t_dp.push_back(mk(1, 1, I1, 1, 0, D5, W, C, 1, 1, 0, D5, W, 0, Z, 1, C));
        t_dp.push_back(mkz(1, 1, I1, 0, 0, Z32, Z, Z, 0));
        t_dp.push_back(mk(1, 1, I1, 0, 0, Z32, Z, A, 1, 1, 0, I1, Z, 1, A, 0, Z));
        t_dp.push_back(mkz(1, 0, Z32, 0, 0, Z32, Z, Z, 0));

        foreach (t_rr[i]) begin
            @(negedge clk);
            applyStimulus(t_rr[i], 0);
            #1;
            checkOutput(t_rr[i], 0, $sformatf("rr[%0d]", i));
        end

        foreach (t_dp[i]) begin
            @(negedge clk);
            applyStimulus(t_dp[i], 1);
            #1;
            checkOutput(t_dp[i], 1, $sformatf("dp[%0d]", i));
        end

        // Reset pulsed mid-grant must clear the port between clock edges,
        // and a late mem_resp must not surface as a response.
        @(negedge clk);
        applyStimulus(mkz(1, 0, Z32, 1, 1'b0, D6, W, Z, 0), 0);
        #1;
        checkOutput(mkz(1, 0, Z32, 1, 0, D6, W, Z, 0), 0, "rst_mid.idle");
        @(negedge clk);
        #1;
        checkOutput(mk(1, 0, Z32, 1, 0, D6, W, Z, 0, 1, 0, D6, W, 0, Z, 0, Z), 0, "rst_mid.grant");
        #1;
        rst_n0 = 1'b0;
        #1;
        checkOutput(mkz(0, 0, Z32, 1, 0, D6, W, Z, 0), 0, "rst_mid.async");
        @(negedge clk);
        applyStimulus(mkz(1, 0, Z32, 0, 0, Z32, Z, A, 1), 0);
        #1;
        checkOutput(mkz(1, 0, Z32, 0, 0, Z32, Z, A, 1), 0, "rst_mid.late_resp");
        @(negedge clk);
        applyStimulus(mkz(1, 0, Z32, 0, 0, Z32, Z, Z, 0), 0);
        #1;
        checkOutput(mkz(1, 0, Z32, 0, 0, Z32, Z, Z, 0), 0, "rst_mid.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
